// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit that owns the HI/LO pair.
// Multiplies take one cycle; divides use a restoring radix-2 iteration with a down-counter.
module hilo_muldiv #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        ack,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] mul_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // state  | meaning
  // S_IDLE | waiting for start, accepts mthi/mtlo
  // S_MUL  | one-cycle product capture
  // S_DIV  | DIV_ITERS restoring-division iterations
  // S_DONE | result held until ack or flush

  localparam logic [5:0] R_TYPE_OP = 6'h00;
  localparam logic [5:0] MUL_OP    = 6'h30;
  localparam logic [5:0] MADD_OP   = 6'h31;
  localparam logic [5:0] MADDU_OP  = 6'h32;
  localparam logic [5:0] MSUB_OP   = 6'h33;
  localparam logic [5:0] MSUBU_OP  = 6'h34;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam int         CW        = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU,
    OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
  } op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d, req_op;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic          signed_op;
  logic [63:0]   ext_a, ext_b, prod, acc;
  logic [31:0]   dvs, rem_nxt, quo_nxt, q_fix, r_fix;
  logic [32:0]   shifted, trial;

  always_comb begin
    req_op = OP_NONE;
    case (aluop)
      MUL_OP:   req_op = OP_MUL;
      MADD_OP:  req_op = OP_MADD;
      MADDU_OP: req_op = OP_MADDU;
      MSUB_OP:  req_op = OP_MSUB;
      MSUBU_OP: req_op = OP_MSUBU;
      R_TYPE_OP: begin
        case (funct)
          F_MULT:  req_op = OP_MULT;
          F_MULTU: req_op = OP_MULTU;
          F_DIV:   req_op = OP_DIV;
          F_DIVU:  req_op = OP_DIVU;
          default: req_op = OP_NONE;
        endcase
      end
      default: req_op = OP_NONE;
    endcase
  end

  // Datapath works on the latched operands; low 64 bits of the extended product
  // are correct for both signed and unsigned operands.
  always_comb begin
    signed_op = op_q inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
    ext_a     = signed_op ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b     = signed_op ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = ext_a * ext_b;
    dvs       = (signed_op && b_q[31]) ? -b_q : b_q;
    shifted   = {rem_q, quo_q[31]};
    trial     = shifted - {1'b0, dvs};
    rem_nxt   = trial[32] ? shifted[31:0] : trial[31:0];
    quo_nxt   = {quo_q[30:0], ~trial[32]};
    q_fix     = (signed_op && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
    r_fix     = (signed_op && a_q[31]) ? -rem_nxt : rem_nxt;
    acc       = {hi_q, lo_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          busy = 1'b1;
          if (req_op != OP_NONE) begin
            op_d = req_op;
            a_d  = src_a;
            b_d  = src_b;
          end
          if (req_op == OP_DIV || req_op == OP_DIVU) begin
            state_d = S_DIV;
            cnt_d   = CNT_LOAD;
            rem_d   = '0;
            quo_d   = (req_op == OP_DIV && src_a[31]) ? -src_a : src_a;
          end else if (req_op != OP_NONE) begin
            state_d = S_MUL;
          end
        end else if (!flush && !start) begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          {res_hi_d, res_lo_d} = prod;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            // Divide by zero bypasses the sign fix-up with a fixed result.
            if (b_q == '0) begin
              res_lo_d = 32'hffff_ffff;
              res_hi_d = a_q;
            end else begin
              res_lo_d = q_fix;
              res_hi_d = r_fix;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (ack) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: {hi_d, lo_d} = {res_hi_q, res_lo_q};
            OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + {res_hi_q, res_lo_q};
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - {res_hi_q, res_lo_q};
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mul_result = res_lo_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vector bench for hilo_muldiv: table of operations plus hand-written
// sequences for held DONE, flush mid-divide, reset mid-multiply and IDLE corner cases.
module tb_hilo_muldiv;

  localparam logic [5:0] R_TYPE_OP = 6'h00;
  localparam logic [5:0] MUL_OP    = 6'h30;
  localparam logic [5:0] MADD_OP   = 6'h31;
  localparam logic [5:0] MADDU_OP  = 6'h32;
  localparam logic [5:0] MSUB_OP   = 6'h33;
  localparam logic [5:0] MSUBU_OP  = 6'h34;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam int         NV        = 13;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, ack, flush;
  logic [5:0]  aluop, funct;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] mul_result, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_mul;
  } vec_t;

  vec_t vecs [NV];

  hilo_muldiv #(.DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .funct(funct),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo), .ack(ack),
    .flush(flush), .busy(busy), .done(done), .mul_result(mul_result),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; src_a = h; tick(); mthi = 1'b0;
    mtlo = 1'b1; src_a = l; tick(); mtlo = 1'b0;
  endtask

  // Drives start for one cycle (cycle 0) and leaves the bench in cycle 1.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    aluop = op; funct = fn; src_a = a; src_b = b; start = 1'b1;
    #1;
    check("busy_on_request", busy, 1);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    set_hilo(v.pre_hi, v.pre_lo);
    issue(v.aluop, v.funct, v.a, v.b);
    wait_done(lat);
    check("latency", lat, v.lat);
    check("busy_in_done", busy, 0);
    if (v.aluop == MUL_OP) check("mul_result", mul_result, v.exp_mul);
    check("no_commit_before_ack", {hi_o, lo_o}, {v.pre_hi, v.pre_lo});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("done_clears", done, 0);
    check("hilo_commit", {hi_o, lo_o}, {v.exp_hi, v.exp_lo});
  endtask

  initial begin
    int lat;
    vecs[0]  = '{R_TYPE_OP, F_MULT,  32'hffff_fffd, 32'd5,          0, 0, 2,  32'hffff_ffff, 32'hffff_fff1, 0};
    vecs[1]  = '{R_TYPE_OP, F_MULTU, 32'hffff_ffff, 32'hffff_ffff, 0, 0, 2,  32'hffff_fffe, 32'h0000_0001, 0};
    vecs[2]  = '{R_TYPE_OP, F_DIV,   32'hffff_fff9, 32'd2,          0, 0, 33, 32'hffff_ffff, 32'hffff_fffd, 0};
    vecs[3]  = '{R_TYPE_OP, F_DIVU,  32'd7,         32'd0,          0, 0, 33, 32'd7,         32'hffff_ffff, 0};
    vecs[4]  = '{MADD_OP,   6'h00,   32'hffff_ffff, 32'd2,          0, 10, 2, 32'd0,         32'd8,         0};
    vecs[5]  = '{MSUBU_OP,  6'h00,   32'd3,         32'd3,          0, 8, 2,  32'hffff_ffff, 32'hffff_ffff, 0};
    vecs[6]  = '{MUL_OP,    6'h02,   32'h0001_0000, 32'h0001_0001, 32'h1234, 32'h5678, 2, 32'h1234, 32'h5678, 32'h0001_0000};
    vecs[7]  = '{R_TYPE_OP, F_DIV,   32'h8000_0000, 32'hffff_ffff, 5, 6, 33, 32'd0,         32'h8000_0000, 0};
    vecs[8]  = '{R_TYPE_OP, F_DIV,   32'd7,         32'hffff_fffe, 0, 0, 33, 32'd1,         32'hffff_fffd, 0};
    vecs[9]  = '{R_TYPE_OP, F_DIV,   32'hffff_fff9, 32'd0,          0, 0, 33, 32'hffff_fff9, 32'hffff_ffff, 0};
    vecs[10] = '{R_TYPE_OP, F_DIVU,  32'hffff_ffff, 32'd10,         0, 0, 33, 32'd5,         32'h1999_9999, 0};
    vecs[11] = '{MADDU_OP,  6'h00,   32'hffff_ffff, 32'hffff_ffff, 0, 1, 2,  32'hffff_fffe, 32'h0000_0002, 0};
    vecs[12] = '{MSUB_OP,   6'h00,   32'hffff_ffff, 32'd1,          0, 0, 2,  32'd0,         32'd1,         0};

    rst = 1'b1; start = 0; mthi = 0; mtlo = 0; ack = 0; flush = 0;
    aluop = 0; funct = 0; src_a = 0; src_b = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_mul_result", mul_result, 0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Both move-to bits in one cycle write both registers.
    mthi = 1'b1; mtlo = 1'b1; src_a = 32'h0000_abcd; tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_both", {hi_o, lo_o}, {32'h0000_abcd, 32'h0000_abcd});

    // Flush overrides start and mthi in IDLE.
    start = 1'b1; flush = 1'b1; mthi = 1'b1; aluop = R_TYPE_OP; funct = F_MULT; src_a = 32'h1111_1111;
    #1;
    check("flush_blocks_busy", busy, 0);
    tick();
    start = 1'b0; flush = 1'b0; mthi = 1'b0;
    check("flush_idle_busy", busy, 0);
    check("flush_idle_hi", hi_o, 32'h0000_abcd);

    // DONE held without ack while start stays high: no restart, no commit.
    set_hilo(0, 0);
    issue(R_TYPE_OP, F_MULT, 32'd2, 32'd3);
    wait_done(lat);
    check("hold_latency", lat, 2);
    start = 1'b1; aluop = R_TYPE_OP; funct = F_DIV; src_a = 32'd99; src_b = 32'd4;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_done", done, 1);
      check("hold_busy", busy, 0);
      check("hold_hilo", {hi_o, lo_o}, 64'd0);
    end
    start = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    check("hold_commit", {hi_o, lo_o}, {32'd0, 32'd6});
    check("hold_idle_done", done, 0);
    check("hold_idle_busy", busy, 0);

    // Flush in cycle 10 of a divide.
    set_hilo(32'h0000_0aaa, 32'h0000_0bbb);
    issue(R_TYPE_OP, F_DIV, 32'd100, 32'd7);
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    #1;
    check("div_busy_cycle10", busy, 1);
    tick();
    flush = 1'b0;
    check("div_flush_busy", busy, 0);
    check("div_flush_done", done, 0);
    for (int k = 0; k < 30; k++) tick();
    check("div_flush_stays_idle", {31'd0, done}, 0);
    check("div_flush_hilo", {hi_o, lo_o}, {32'h0000_0aaa, 32'h0000_0bbb});

    // Reset in the MUL cycle.
    set_hilo(32'h0000_0123, 32'h0000_0456);
    issue(R_TYPE_OP, F_MULTU, 32'd9, 32'd9);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_mul_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_mid_mul_done", done, 0);
    check("rst_mid_mul_busy", busy, 0);
    tick();
    check("rst_mid_mul_no_done", done, 0);
    check("rst_mid_mul_result", mul_result, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage multiply/divide unit and owner of the HI/LO register pair.
- Acts as the responder for the decoder's DivMulEnD request, registered into E as start.
- Executes MULT, MULTU, DIV, DIVU, MUL, MADD, MADDU, MSUB and MSUBU as multi-cycle operations, and MTHI/MTLO as single-cycle writes.
- Stalls the pipeline through busy and holds the result until the pipeline acknowledges it.

Parameters:
- DIV_ITERS, 32: radix-2 divide iterations; must equal the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request from decode (DivMulEn), registered into E
- aluop  in  6  ALU op code, using the shared define-header encodings (MUL_OP, MADD_OP, MADDU_OP, MSUB_OP, MSUBU_OP, R_TYPE_OP)
- funct  in  6  instr[5:0]; with R_TYPE_OP selects MULT/MULTU/DIV/DIVU
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- mthi  in  1  write src_a to HI
- mtlo  in  1  write src_a to LO
- ack  in  1  pipeline accepts the DONE result (E advancing)
- flush  in  1  exception/eret flush; aborts the operation
- busy  out  1  stall request
- done  out  1  result ready and held
- mul_result  out  32  low 32 bits of the MUL product (GPR writeback)
- hi_o  out  32  committed HI
- lo_o  out  32  committed LO

Behaviour:
- Reset (rst=1 at clk edge, any state):
  - state=IDLE, HI=LO=0, mul_result=0, iteration counter=0.
  - Any in-flight operation is discarded.
  - busy and done are 0 in the cycle after reset.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start & ~flush: latch aluop, funct, src_a and src_b.
  - Go to MUL for the MULT, MULTU, MUL, MADD, MADDU, MSUB and MSUBU classes; go to DIV for DIV and DIVU.
  - start is ignored in every state other than IDLE.
- MUL: one cycle. Register the 64-bit product (signed or unsigned per op), then go to DONE.
- DIV: DIV_ITERS cycles of restoring division on absolute values, then go to DONE. Sign fix-up happens on DONE entry:
  - Quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero (any signedness) gives LO=0xFFFFFFFF, HI=src_a.
- DONE:
  - done=1, busy=0; results are held stable.
  - On ack & ~flush: commit to HI/LO at the clock edge and go to IDLE.
  - On flush: go to IDLE with no commit.
- Commit rules:
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MADDU: {HI,LO} += product. MSUB/MSUBU: {HI,LO} -= product. All are 64-bit with wrap-around.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - MUL: mul_result = product[31:0] is valid while done=1; HI/LO are unchanged.
- busy = (IDLE & start & ~flush) | MUL | DIV. It is combinational from start, so the request cycle stalls.
- Latency from the start cycle (cycle 0):
  - Multiply class: done in cycle 2.
  - Divide: done in cycle DIV_ITERS+1 (33).
  - HI/LO update at the end of the first DONE cycle that has ack.
- flush in MUL or DIV: go to IDLE next cycle, HI/LO unchanged, busy=0 next cycle. flush overrides start, ack, mthi and mtlo.
- mthi/mtlo:
  - Accepted only in IDLE with ~flush and no start.
  - Write at the clock edge; visible on hi_o/lo_o in the next cycle.
  - If both are set, both registers are written.
  - Ignored in other states; the pipeline never issues them while busy.
- hi_o/lo_o are always the registered committed values; there is no internal bypass.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5, ack=1 at DONE → done in cycle 2; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 2 → busy for cycles 0..32, done in cycle 33; commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- MTLO 10, MTHI 0, then MADD 0xFFFFFFFF * 0x00000002 → HI=0, LO=8. MSUBU 3*3 on HI=0, LO=8 → HI=LO=0xFFFFFFFF.
- MUL 0x00010000 * 0x00010001 → mul_result=0x00010000 while done; HI/LO unchanged.
- Hold ack=0 in DONE for 5 cycles with start still high → done stays 1, no restart, no commit; commit occurs when ack rises.
- flush at cycle 10 of DIV → IDLE next cycle, busy=0, HI/LO unchanged. rst mid-MUL → HI=LO=0, done=0.
